// File: rtl/rate_limit_scheduler.sv
// rate_limit_scheduler: four slew-limited channels sharing one round-robin step engine
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   req_valid    load request present; req_ready accepts it (low only when req_ch is being stepped)
//   req_ch       channel addressed by the load
//   req_target   new 6-bit unsigned target
//   req_step     per-step slew limit, 0..7
//   ch_out       packed current values, ch_out[6i+5:6i] is channel i
//   ch_busy      channel i is ramping toward its target
//   ch_done      one-cycle pulse when channel i reaches its target
//   grant_valid  a channel is stepped this cycle, grant_ch names it
module rate_limit_scheduler #(
  parameter int NUM_CH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_ch,
  input  logic [5:0]        req_target,
  input  logic [2:0]        req_step,
  output logic [6*NUM_CH-1:0] ch_out,
  output logic [NUM_CH-1:0] ch_busy,
  output logic [NUM_CH-1:0] ch_done,
  output logic              grant_valid,
  output logic [1:0]        grant_ch
);
  typedef enum logic {IDLE, RAMP} ch_state_t;
  ch_state_t         st [NUM_CH];
  ch_state_t         st_n [NUM_CH];
  logic [5:0]        cur [NUM_CH];
  logic [5:0]        cur_n [NUM_CH];
  logic [5:0]        tgt [NUM_CH];
  logic [5:0]        tgt_n [NUM_CH];
  logic [2:0]        stp [NUM_CH];
  logic [2:0]        stp_n [NUM_CH];
  logic [NUM_CH-1:0] done, done_n;
  logic [1:0]        rr, rr_n;
  logic [6:0]        up, dn;
  logic [5:0]        nxt;
  logic              accept;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_out
    assign ch_out[6*i +: 6] = cur[i];
    assign ch_busy[i] = st[i] == RAMP;
  end
  assign ch_done = done;
  assign grant_valid = |ch_busy;
  assign req_ready = !(grant_valid && req_ch == grant_ch);
  assign accept = req_valid && req_ready;
  // Descending scan so the last hit is the busy channel closest to rr.
  always_comb begin
    grant_ch = rr;
    for (int k = NUM_CH - 1; k >= 0; k--)
      if (ch_busy[rr + 2'(k)]) grant_ch = rr + 2'(k);
  end
  // 7-bit arithmetic: overshoot shows up as >63 going up or negative going down, then clamps to tgt.
  always_comb begin
    up = {1'b0, cur[grant_ch]} + {4'b0, stp[grant_ch]};
    dn = {1'b0, cur[grant_ch]} - {4'b0, stp[grant_ch]};
    nxt = tgt[grant_ch] > cur[grant_ch]
        ? (up > {1'b0, tgt[grant_ch]} ? tgt[grant_ch] : up[5:0])
        : ($signed(dn) < $signed({1'b0, tgt[grant_ch]}) ? tgt[grant_ch] : dn[5:0]);
  end
  // A load never collides with the granted channel (req_ready), so both updates can coexist.
  always_comb begin
    cur_n = cur;
    tgt_n = tgt;
    stp_n = stp;
    st_n = st;
    done_n = '0;
    rr_n = rr;
    if (grant_valid) begin
      cur_n[grant_ch] = nxt;
      rr_n = grant_ch + 2'd1;
      if (nxt == tgt[grant_ch]) begin
        st_n[grant_ch] = IDLE;
        done_n[grant_ch] = 1'b1;
      end
    end
    if (accept) begin
      tgt_n[req_ch] = req_target;
      stp_n[req_ch] = req_step;
      st_n[req_ch] = (req_target != cur[req_ch] && |req_step) ? RAMP : IDLE;
      done_n[req_ch] = req_target == cur[req_ch];
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cur <= '{default: '0};
      tgt <= '{default: '0};
      stp <= '{default: '0};
      st <= '{default: IDLE};
      done <= '0;
      rr <= '0;
    end else begin
      cur <= cur_n;
      tgt <= tgt_n;
      stp <= stp_n;
      st <= st_n;
      done <= done_n;
      rr <= rr_n;
    end
endmodule

// File: tb/tb_rate_limit_scheduler.sv
// tb_rate_limit_scheduler: self-checking bench for rate_limit_scheduler
module tb_rate_limit_scheduler;
  logic        clk, rst, req_valid, req_ready, grant_valid;
  logic [1:0]  req_ch, grant_ch;
  logic [5:0]  req_target;
  logic [2:0]  req_step;
  logic [23:0] ch_out;
  logic [3:0]  ch_busy, ch_done;
  int checks = 0;
  int errors = 0;
  logic [5:0] exp_q[$];
  logic [1:0] gnt_q[$];

  rate_limit_scheduler #(.NUM_CH(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_ch(req_ch), .req_target(req_target), .req_step(req_step),
    .ch_out(ch_out), .ch_busy(ch_busy), .ch_done(ch_done),
    .grant_valid(grant_valid), .grant_ch(grant_ch)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [1:0] c, input logic [5:0] t, input logic [2:0] s);
    req_valid = 1;
    req_ch = c;
    req_target = t;
    req_step = s;
  endtask

  task automatic load(input logic [1:0] c, input logic [5:0] t, input logic [2:0] s);
    set_req(c, t, s);
    tick();
    req_valid = 0;
  endtask

  // Pops one expected value per cycle, then checks busy duration and a single done pulse.
  task automatic drain(input int ch);
    int n, busy_cyc, dones;
    logic [5:0] e;
    n = exp_q.size();
    busy_cyc = ch_busy[ch] ? 1 : 0;
    dones = 0;
    while (exp_q.size() > 0) begin
      tick();
      e = exp_q.pop_front();
      checks++;
      if (ch_out[6*ch +: 6] !== e) begin
        errors++;
        $display("FAIL ramp ch%0d got %0d want %0d", ch, ch_out[6*ch +: 6], e);
      end
      if (ch_busy[ch]) busy_cyc++;
      if (ch_done[ch]) dones++;
    end
    tick();
    if (ch_done[ch]) dones++;
    checks++;
    if (busy_cyc != n) begin
      errors++;
      $display("FAIL busy_cycles ch%0d got %0d want %0d", ch, busy_cyc, n);
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL done_pulses ch%0d got %0d want 1", ch, dones);
    end
  endtask

  task automatic test_reset();
    rst = 0;
    req_valid = 0;
    req_ch = 0;
    req_target = 0;
    req_step = 0;
    #2;
    checks++;
    if (ch_out !== 24'd0 || ch_busy !== 4'd0 || ch_done !== 4'd0) begin
      errors++;
      $display("FAIL reset_state got out=%h busy=%b done=%b want 0/0/0", ch_out, ch_busy, ch_done);
    end
    checks++;
    if (grant_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_handshake got gv=%b rdy=%b want 0/1", grant_valid, req_ready);
    end
    #11 rst = 1;
    tick();
  endtask

  task automatic test_increment();
    load(0, 30, 7);
    checks++;
    if (grant_valid !== 1'b1 || grant_ch !== 2'd0) begin
      errors++;
      $display("FAIL inc_grant got gv=%b ch=%0d want 1/0", grant_valid, grant_ch);
    end
    exp_q = '{7, 14, 21, 28, 30};
    drain(0);
  endtask

  task automatic test_decrement();
    load(0, 15, 7);
    exp_q = '{23, 16, 15};
    drain(0);
  endtask

  task automatic test_arbitration();
    int cyc, t1, t2;
    logic [1:0] e;
    t1 = -1;
    t2 = -1;
    cyc = 0;
    gnt_q = '{1, 2, 1, 2, 1};
    set_req(1, 12, 4);
    tick();
    set_req(2, 8, 4);
    while (gnt_q.size() > 0) begin
      e = gnt_q.pop_front();
      checks++;
      if (grant_valid !== 1'b1 || grant_ch !== e) begin
        errors++;
        $display("FAIL arb_grant got gv=%b ch=%0d want 1/%0d", grant_valid, grant_ch, e);
      end
      tick();
      req_valid = 0;
      cyc++;
      if (ch_done[2] && t2 < 0) t2 = cyc;
      if (ch_done[1] && t1 < 0) t1 = cyc;
    end
    checks++;
    if (ch_out[11:6] !== 6'd12 || ch_out[17:12] !== 6'd8) begin
      errors++;
      $display("FAIL arb_values got ch1=%0d ch2=%0d want 12/8", ch_out[11:6], ch_out[17:12]);
    end
    checks++;
    if (t2 != 4 || t1 != 5) begin
      errors++;
      $display("FAIL arb_done_order got ch2@%0d ch1@%0d want 4/5", t2, t1);
    end
    checks++;
    if (grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL arb_idle got gv=%b want 0", grant_valid);
    end
  endtask

  task automatic test_boundaries();
    load(3, 60, 7);
    exp_q = '{7, 14, 21, 28, 35, 42, 49, 56, 60};
    drain(3);
    load(3, 63, 7);
    exp_q = '{63};
    drain(3);
    load(3, 5, 7);
    exp_q = '{56, 49, 42, 35, 28, 21, 14, 7, 5};
    drain(3);
    load(3, 2, 6);
    exp_q = '{2};
    drain(3);
    load(3, 40, 0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ch_out[23:18] !== 6'd2 || ch_busy[3] !== 1'b0 || ch_done[3] !== 1'b0) begin
        errors++;
        $display("FAIL step0 got cur=%0d busy=%b done=%b want 2/0/0", ch_out[23:18], ch_busy[3], ch_done[3]);
      end
      tick();
    end
    load(3, 2, 5);
    checks++;
    if (ch_done[3] !== 1'b1 || ch_busy[3] !== 1'b0) begin
      errors++;
      $display("FAIL same_target got done=%b busy=%b want 1/0", ch_done[3], ch_busy[3]);
    end
    tick();
    checks++;
    if (ch_done[3] !== 1'b0) begin
      errors++;
      $display("FAIL same_target_pulse got done=%b want 0", ch_done[3]);
    end
  endtask

  task automatic test_reset_mid();
    load(0, 63, 1);
    tick();
    tick();
    #2 rst = 0;
    #1;
    checks++;
    if (ch_out !== 24'd0 || ch_busy !== 4'd0 || ch_done !== 4'd0) begin
      errors++;
      $display("FAIL mid_reset got out=%h busy=%b done=%b want 0/0/0", ch_out, ch_busy, ch_done);
    end
    checks++;
    if (grant_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_hs got gv=%b rdy=%b want 0/1", grant_valid, req_ready);
    end
    tick();
    checks++;
    if (ch_done !== 4'd0 || ch_out !== 24'd0) begin
      errors++;
      $display("FAIL mid_reset_hold got out=%h done=%b want 0/0", ch_out, ch_done);
    end
    #2 rst = 1;
    tick();
  endtask

  task automatic test_collision();
    set_req(1, 40, 2);
    tick();
    set_req(2, 40, 2);
    tick();
    req_valid = 0;
    tick();
    set_req(1, 20, 3);
    #1;
    checks++;
    if (req_ready !== 1'b0 || grant_ch !== 2'd1) begin
      errors++;
      $display("FAIL collide_block got rdy=%b gnt=%0d want 0/1", req_ready, grant_ch);
    end
    tick();
    checks++;
    if (req_ready !== 1'b1 || grant_ch !== 2'd2) begin
      errors++;
      $display("FAIL collide_accept got rdy=%b gnt=%0d want 1/2", req_ready, grant_ch);
    end
    tick();
    req_valid = 0;
    checks++;
    if (ch_out[11:6] !== 6'd4 || ch_out[17:12] !== 6'd4) begin
      errors++;
      $display("FAIL collide_hold got ch1=%0d ch2=%0d want 4/4", ch_out[11:6], ch_out[17:12]);
    end
    tick();
    checks++;
    if (ch_out[11:6] !== 6'd7) begin
      errors++;
      $display("FAIL retarget_step got %0d want 7", ch_out[11:6]);
    end
    tick();
    tick();
    checks++;
    if (ch_out[11:6] !== 6'd10 || ch_busy[1] !== 1'b1) begin
      errors++;
      $display("FAIL retarget_ramp got cur=%0d busy=%b want 10/1", ch_out[11:6], ch_busy[1]);
    end
  endtask

  initial begin
    test_reset();
    test_increment();
    test_decrement();
    test_arbitration();
    test_boundaries();
    test_reset_mid();
    test_collision();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rate_limit_scheduler.md
RATE_LIMIT_SCHEDULER -- requirements
Module: rate_limit_scheduler

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent slew channels; fixed at 4 in this revision, so channel index is 2 bits.
REQ-002 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous assert, active-low.
REQ-004 SHALL have port req_valid, input, 1 bit: load request present.
REQ-005 SHALL have port req_ready, output, 1 bit: load request accepted this cycle when high together with req_valid.
REQ-006 SHALL have port req_ch, input, 2 bits: channel addressed by the load.
REQ-007 SHALL have port req_target, input, 6 bits: new target value, unsigned.
REQ-008 SHALL have port req_step, input, 3 bits: per-step slew limit, unsigned, 0..7.
REQ-009 SHALL have port ch_out, output, 24 bits: current value of each channel, packed; ch_out[6i+5:6i] is channel i.
REQ-010 SHALL have port ch_busy, output, 4 bits: channel i is ramping, ch_out(i) != target(i).
REQ-011 SHALL have port ch_done, output, 4 bits: one-cycle pulse when channel i reaches its target.
REQ-012 SHALL have port grant_valid, output, 1 bit: one channel is being stepped this cycle.
REQ-013 SHALL have port grant_ch, output, 2 bits: index of the stepped channel, valid only with grant_valid.

Function
REQ-014 SHALL keep per-channel registers cur, tgt and step, plus a busy flag; ch_out and ch_busy SHALL be driven directly from cur and busy.
REQ-015 SHALL share one slew engine: at most one channel updated per clock.
REQ-016 SHALL select the grant combinationally from registered busy, round-robin starting at rr_ptr; rr_ptr SHALL advance to grant_ch+1 (mod 4) after each grant; grant_valid = |busy.
REQ-017 SHALL update the granted channel at the clock edge; if tgt>cur, cur = min(cur+step, tgt); if tgt<cur, cur = max(cur-step, tgt).
REQ-018 SHALL compute the step arithmetic at 7 bits, so there is no wrap-around; cur never passes tgt and stays within 0..63.
REQ-019 SHALL clear busy on the same edge at which cur becomes equal to tgt, and SHALL pulse ch_done(i) high for exactly the following cycle.
REQ-020 SHALL set req_ready = 0 only when grant_valid=1 and req_ch equals grant_ch; it SHALL be 1 otherwise.
REQ-021 SHALL capture tgt and step on an accepted load; busy SHALL be set at that edge if req_target != cur and req_step != 0; the channel SHALL first become eligible for grant in the next cycle.
REQ-022 SHALL, for an accepted load with req_target == cur, leave busy at 0 and pulse ch_done the next cycle.
REQ-023 SHALL, for an accepted load with req_step == 0 and req_target != cur, leave cur frozen and busy 0, with no ch_done pulse.
REQ-024 SHALL treat a load to a busy channel, not currently granted, as a retarget: cur continues from its present value toward the new tgt with the new step.
REQ-025 SHALL keep per-channel state as IDLE (busy=0) or RAMP (busy=1), with IDLE->RAMP on load and RAMP->IDLE on reaching target or on a retarget to the current value.

Reset
REQ-026 SHALL, while rst=0, asynchronously force cur, tgt and step to 0, busy=0, ch_done=0 and rr_ptr=0, which makes grant_valid=0 and req_ready=1.
REQ-027 SHALL abandon an in-progress ramp on reset assertion with no ch_done pulse; operation SHALL resume on the first rising edge after rst returns high.

Verification
REQ-028 SHALL cover reset: rst=0 mid-ramp -> ch_out=0, ch_busy=0, ch_done=0 and grant_valid=0 immediately, without a clock edge.
REQ-029 SHALL cover increment: load ch0 with target 30, step 7 -> ch0 reads 7,14,21,28,30 on consecutive cycles; busy is high for 5 cycles; ch_done[0] pulses once.
REQ-030 SHALL cover decrement: ch0 at 30, load target 15, step 7 -> 23,16,15, then ch_done[0].
REQ-031 SHALL cover arbitration: load ch1 (12, step 4) then ch2 (8, step 4) on back-to-back cycles -> grant_ch sequence 1,2,1,2,1; ch2 done at 8 before ch1 done at 12.
REQ-032 SHALL cover boundaries: ch3 from 60 to target 63, step 7 -> 63 with no wrap to 3; ch3 from 5 to target 2, step 6 -> 2 with no wrap to 63; step 0 -> cur unchanged, no busy.
REQ-033 SHALL cover the collision: req_valid to ch1 while ch1 is granted -> req_ready=0 for that cycle; the load is accepted the next cycle; ramp retargets from the current value.
